conv33_output_fifo: RTL and testbench

CONV33_OUTPUT_FIFO -- requirements
Module: conv33_output_fifo

---
 rtl/conv33_output_fifo_pkg.sv | 20 ++
 rtl/conv_relu_lane.sv | 28 ++
 rtl/conv33_output_fifo.sv | 128 ++++++++++++
 tb/tb_conv33_output_fifo.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/conv33_output_fifo_pkg.sv
// ---------------------------------------------------------------------------
// conv33_output_fifo_pkg
// Shared conv package for the conv33 datapath: default lane width, default
// lane count, and the helper that computes the packed width of a word made
// of several lanes.
// ---------------------------------------------------------------------------
package conv33_output_fifo_pkg;

   // Default signed width of one output-channel lane result.
   localparam int CONV_OUT_WIDTH = 32;

   // Default number of output-channel lanes packed into one word.
   localparam int CONV_NUM_CH = 4;

   // Width of a word that packs num_ch lanes of out_width bits each.
   function automatic int lane_pack_width(input int out_width, input int num_ch);
      return out_width * num_ch;
   endfunction

endpackage

// File: rtl/conv_relu_lane.sv
// ---------------------------------------------------------------------------
// conv_relu_lane
// Combinational per-lane clamp: when en is high and the lane is negative the
// lane is replaced by zero, otherwise it passes through untouched.
// Ports:
//   din  - signed lane value (OUT_WIDTH bits)
//   en   - clamp enable
//   dout - clamped lane value (OUT_WIDTH bits)
// ---------------------------------------------------------------------------
module conv_relu_lane #(
   parameter int OUT_WIDTH = 32
) (
   input  logic [OUT_WIDTH-1:0] din,
   input  logic                 en,
   output logic [OUT_WIDTH-1:0] dout
);

   // Clamp negative lanes to zero when enabled.
   always_comb begin
      dout = din;
      if (en && din[OUT_WIDTH-1]) begin
         dout = '0;
      end else begin
         dout = din;
      end
   end

endmodule

// File: rtl/conv33_output_fifo.sv
// ---------------------------------------------------------------------------
// conv33_output_fifo
// Show-ahead output FIFO for the conv33 datapath. Each word packs NUM_CH
// signed lanes of OUT_WIDTH bits; lanes can be clamped to zero on write
// (relu_en sampled per push). A push refused while full sets a sticky
// overflow flag.
// Ports:
//   clk, rst         - clock, asynchronous active-high reset
//   in_valid/in_ready/in_data - write handshake and packed word
//   relu_en          - clamp negative lanes of the word being pushed
//   out_valid/out_ready/out_data - read handshake and head word
//   count            - number of stored words (0..DEPTH)
//   overflow/clr_ovf - sticky refused-push flag and its synchronous clear
// ---------------------------------------------------------------------------
module conv33_output_fifo
   import conv33_output_fifo_pkg::*;
#(
   parameter int OUT_WIDTH = CONV_OUT_WIDTH,
   parameter int NUM_CH    = CONV_NUM_CH,
   parameter int DEPTH     = 8
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         in_valid,
   input  logic [lane_pack_width(OUT_WIDTH, NUM_CH)-1:0] in_data,
   output logic                                         in_ready,
   input  logic                                         relu_en,
   output logic                                         out_valid,
   output logic [lane_pack_width(OUT_WIDTH, NUM_CH)-1:0] out_data,
   input  logic                                         out_ready,
   output logic [$clog2(DEPTH):0]                       count,
   output logic                                         overflow,
   input  logic                                         clr_ovf
);

   localparam int AW = $clog2(DEPTH);
   localparam int DW = lane_pack_width(OUT_WIDTH, NUM_CH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   logic [DW-1:0] mem_r [DEPTH];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [AW:0]   count_r;
   logic [AW:0]   count_nxt_s;
   logic          in_ready_r;
   logic          out_valid_r;
   logic          overflow_r;
   logic          push_s;
   logic          pop_s;
   logic [DW-1:0] wdata_s;

   // One clamp instance per lane; relu_en applies to the word being pushed.
   for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      conv_relu_lane #(
         .OUT_WIDTH (OUT_WIDTH)
      ) u_relu (
         .din  (in_data[k*OUT_WIDTH +: OUT_WIDTH]),
         .en   (relu_en),
         .dout (wdata_s[k*OUT_WIDTH +: OUT_WIDTH])
      );
   end

   // Handshake qualification: both flags come from registers, so in_ready
   // never depends on out_ready and a full FIFO refuses a push even when
   // it pops in the same cycle.
   always_comb begin
      push_s = in_valid && in_ready_r;
      pop_s  = out_valid_r && out_ready;
   end

   // Next occupancy: simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_nxt_s = count_r;
      case ({push_s, pop_s})
         2'b10:   count_nxt_s = count_r + (AW+1)'(1);
         2'b01:   count_nxt_s = count_r - (AW+1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // Pointers, occupancy and status flags; pointers wrap naturally at DEPTH.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_r    <= '0;
         rd_ptr_r    <= '0;
         count_r     <= '0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         if (push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         count_r     <= count_nxt_s;
         in_ready_r  <= (count_nxt_s != FULL_COUNT);
         out_valid_r <= (count_nxt_s != (AW+1)'(0));
      end
   end

   // Sticky overflow: a refused push wins over a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_r <= 1'b0;
      end else if (in_valid && !in_ready_r) begin
         overflow_r <= 1'b1;
      end else if (clr_ovf) begin
         overflow_r <= 1'b0;
      end else begin
         overflow_r <= overflow_r;
      end
   end

   // Storage array without reset so it maps onto distributed RAM.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= wdata_s;
      end
   end

   assign out_data  = mem_r[rd_ptr_r];
   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign count     = count_r;
   assign overflow  = overflow_r;

endmodule

// File: tb/tb_conv33_output_fifo.sv
// ---------------------------------------------------------------------------
// tb_conv33_output_fifo
// Self-checking bench for conv33_output_fifo (OUT_WIDTH=32, NUM_CH=4,
// DEPTH=8). The stimulus thread pushes the expected stored word into a
// queue whenever a push is accepted; a monitor on the falling edge pops and
// compares whenever out_valid && out_ready. Status outputs are compared with
// a small occupancy/overflow model after each edge.
// ---------------------------------------------------------------------------
module tb_conv33_output_fifo;

   localparam int W  = 32;
   localparam int NC = 4;
   localparam int D  = 8;
   localparam int DW = W * NC;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          in_ready;
   logic          relu_en;
   logic          out_valid;
   logic [DW-1:0] out_data;
   logic          out_ready;
   logic [3:0]    count;
   logic          overflow;
   logic          clr_ovf;

   int errors = 0;
   int checks = 0;
   int mcount = 0;
   logic movf = 1'b0;
   logic [DW-1:0] exp_q[$];

   conv33_output_fifo #(
      .OUT_WIDTH (W),
      .NUM_CH    (NC),
      .DEPTH     (D)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .relu_en   (relu_en),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count),
      .overflow  (overflow),
      .clr_ovf   (clr_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Pack four signed lanes; a3 lands in the most significant lane.
   function automatic logic [DW-1:0] pack(input int a3, input int a2, input int a1, input int a0);
      logic [31:0] l3, l2, l1, l0;
      l3 = a3; l2 = a2; l1 = a1; l0 = a0;
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [DW-1:0] relu_model(input logic [DW-1:0] d, input logic en);
      logic [DW-1:0] r;
      r = d;
      for (int k = 0; k < NC; k++) begin
         if (en && d[k*W + W-1]) r[k*W +: W] = '0;
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // One clock cycle of stimulus; model tracks acceptance, count and overflow.
   task automatic cycle(input logic v, input logic [DW-1:0] d, input logic r,
                        input logic rdy, input logic clr);
      logic acc;
      logic pop;
      in_valid  = v;
      in_data   = d;
      relu_en   = r;
      out_ready = rdy;
      clr_ovf   = clr;
      acc = v && (mcount != D);
      pop = rdy && (mcount != 0);
      if (acc) exp_q.push_back(relu_model(d, r));
      if (v && !acc) movf = 1'b1;
      else if (clr) movf = 1'b0;
      mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
      @(posedge clk);
      #1;
      chk("count", DW'(count), DW'(mcount));
      chk("in_ready", DW'(in_ready), DW'(mcount != D));
      chk("out_valid", DW'(out_valid), DW'(mcount != 0));
      chk("overflow", DW'(overflow), DW'(movf));
   endtask

   // Scoreboard monitor: compare each word as the consumer takes it.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL pop_unexpected: got %h expected no word", out_data);
         end else begin
            logic [DW-1:0] e;
            e = exp_q.pop_front();
            if (out_data !== e) begin
               errors++;
               $display("FAIL pop_data: got %h expected %h", out_data, e);
            end
         end
      end
   end

   initial begin
      logic [DW-1:0] junk;
      junk      = pack(111, -222, 333, -444);
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      relu_en   = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      #12;
      chk("rst_count", DW'(count), DW'(0));
      chk("rst_in_ready", DW'(in_ready), DW'(1));
      chk("rst_out_valid", DW'(out_valid), DW'(0));
      chk("rst_overflow", DW'(overflow), DW'(0));
      rst = 1'b0;

      // First push right after reset release, no relu, no pop.
      cycle(1'b1, pack(5, -3, 0, 7), 1'b0, 1'b0, 1'b0);
      chk("first_word", out_data, pack(5, -3, 0, 7));

      // Relu word pushed behind it, then both popped.
      cycle(1'b1, pack(-1, 2, -32768, 4), 1'b1, 1'b0, 1'b0);
      chk("relu_hand", exp_q[1], pack(0, 2, 0, 4));
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      chk("relu_head", out_data, pack(0, 2, 0, 4));
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Fill to DEPTH with relu toggling per word.
      for (int i = 0; i < D; i++) begin
         cycle(1'b1, pack(i + 1, -(i + 10), 100 * i, -1), 1'(i % 2), 1'b0, 1'b0);
      end
      cycle(1'b1, junk, 1'b0, 1'b0, 1'b0);
      chk("full_head_kept", out_data, pack(1, -10, 0, -1));
      cycle(1'b1, junk, 1'b0, 1'b0, 1'b1);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Full with push and pop together: only the pop happens.
      cycle(1'b1, junk, 1'b0, 1'b1, 1'b0);
      cycle(1'b1, pack(-7, 8, -9, 10), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);

      // Drain to 3 and stream 20 words across pointer wrap.
      for (int i = 0; i < 5; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) begin
         cycle(1'b1, pack(1000 + i, -i, i, -2000), 1'(i % 3 == 0), 1'b1, 1'b0);
      end
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);

      // Fill to 5 and apply reset between edges.
      for (int i = 0; i < 5; i++) cycle(1'b1, pack(i, i, -i, -i), 1'b0, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      chk("async_count", DW'(count), DW'(0));
      chk("async_out_valid", DW'(out_valid), DW'(0));
      chk("async_in_ready", DW'(in_ready), DW'(1));
      exp_q.delete();
      mcount = 0;
      movf   = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      cycle(1'b1, pack(42, -42, 43, -43), 1'b1, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
      chk("scoreboard_empty", DW'(exp_q.size()), DW'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
